mips_ex_bru: RTL and testbench
==============================

// Module: mips_ex_bru
// PURPOSE
//  Self-contained EX-stage branch resolution unit; replaces shared-ALU compare requests.
//  Evaluates BEQ/BNE/BGEZ/BLTZ/BLEZ/BGTZ against the IF-stage direction prediction.
//  Emits a registered predictor-update pulse and, on mispredict, a flush pulse plus a
//  held redirect request to IF (valid/ready handshake).
// PARAMETERS
//  DATA_W  `MIPS_DATA_WIDTH   operand width (rs/rt/imm)
//  ADDR_W  `MIPS_ADDR_WIDTH   PC width
//  CNT_W   32                 statistics counter width
// PORTS
//  clk               in   1        core clock
//  rst_n             in   1        asynchronous, active-low reset
//  bru_i_valid       in   1        EX branch op valid
//  bru_i_ready       out  1        unit can accept (state IDLE)
//  bru_i_rs          in   DATA_W   rs operand (forwarded)
//  bru_i_rt          in   DATA_W   rt operand (forwarded)
//  bru_i_imm         in   DATA_W   sign-extended offset (words)
//  bru_i_pc_incr     in   ADDR_W   PC+4 of branch
//  bru_i_info        in   `MIPS_DECINFO_WIDTH  decode info; BJP_* bits used
//  bru_i_pred_taken  in   1        IF direction prediction for this branch
//  bru_o_flush       out  1        1-cycle pulse: kill younger IF/ID ops
//  bru_o_redir_valid out  1        redirect request to IF
//  bru_o_redir_ready in   1        IF accepts redirect
//  bru_o_redir_pc    out  ADDR_W   corrected fetch PC
//  bru_o_upd_valid   out  1        1-cycle predictor update pulse
//  bru_o_upd_pc      out  ADDR_W   branch PC (pc_incr-4)
//  bru_o_upd_taken   out  1        resolved direction
//  bru_o_br_cnt      out  CNT_W    branches resolved (stats)
//  bru_o_mis_cnt     out  CNT_W    mispredicts (stats)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-redirect aborts it, no flush.
//  - FSM IDLE/REDIR. bru_i_ready = (state==IDLE). Accept = bru_i_valid & bru_i_ready.
//  - Compare: eq/ne on full rs vs rt; gez/ltz/lez/gtz on signed rs. Multi-hot BJP bits
//    illegal; priority BEQ>BNE>BGEZ>BLTZ>BLEZ>BGTZ. No BJP bit: accept, no update, no flush.
//  - Target = pc_incr + (imm[ADDR_W-3:0]<<2), modulo 2^ADDR_W (wrap, no trap).
//  - Latency 1: cycle after accept, upd_valid=1 for exactly 1 cycle with upd_pc/upd_taken.
//  - Mispredict = taken != pred_taken. Same cycle as upd_valid: flush=1 (1 cycle),
//    redir_valid=1, redir_pc = taken ? target : pc_incr; state->REDIR.
//  - REDIR: redir_valid/redir_pc held stable until redir_ready; ready sampled with
//    redir_valid -> IDLE next cycle (may be first REDIR cycle). No accepts while REDIR.
//  - Correct prediction: no flush/redirect, stays IDLE, back-to-back accepts allowed.
//  - upd_*/redir_* and flush are registered; no combinational in->out path.
// CONFIGURATION
//  MIPS_BRU_STATS_EN defined: br_cnt +1 per resolved BJP op, mis_cnt +1 per mispredict;
//   both saturate at 2^CNT_W-1, cleared only by reset.
//  Undefined: counter flops absent; bru_o_br_cnt/bru_o_mis_cnt tied 0; ports unchanged.
// STRUCTURE
//  - Shared defines/package: MIPS_DECINFO_BJP_* bit indices, DECINFO width,
//    BRU state encodings (MIPS_BRU_ST_IDLE/REDIR).
//  - Sub-module mips_ex_bru_cmp: combinational taken/target from rs, rt, imm, pc_incr, info.
//  - Top holds FSM, output regs, optional stats counters.
// TESTING
//  1 BEQ rs=rt=5, pred=1 -> next cycle upd_valid=1,taken=1; flush=0, redir_valid=0.
//  2 BNE rs=rt=7, pred=1, pc_incr=0x104 -> flush pulse, redir_pc=0x104; ready held 0 3 cycles
//    -> redir_valid/pc stable, bru_i_ready=0; ready=1 -> IDLE next cycle.
//  3 BLTZ rs=0x80000000, pred=0, imm=-2, pc_incr=0x200 -> taken, redir_pc=0x1F8.
//  4 BGEZ rs=0, imm=1, pc_incr=0xFFFFFFFC, pred=0 -> redir_pc=0x0 (wrap).
//  5 rst_n low during REDIR -> all outputs 0 immediately; after release bru_i_ready=1.
//  6 STATS_EN, CNT_W=2: 5 mispredicts -> br_cnt=mis_cnt=3 (saturate); no-BJP op: cnt unchanged.

Source files
------------

// File: rtl/mips_ex_bru_pkg.sv
// mips_ex_bru_pkg: shared widths, decode-info bit indices and branch unit state encoding
package mips_ex_bru_pkg;
    localparam int MIPS_DATA_WIDTH      = 32;
    localparam int MIPS_ADDR_WIDTH      = 32;
    localparam int MIPS_DECINFO_WIDTH   = 8;
    localparam int MIPS_DECINFO_BJP_BEQ  = 0;
    localparam int MIPS_DECINFO_BJP_BNE  = 1;
    localparam int MIPS_DECINFO_BJP_BGEZ = 2;
    localparam int MIPS_DECINFO_BJP_BLTZ = 3;
    localparam int MIPS_DECINFO_BJP_BLEZ = 4;
    localparam int MIPS_DECINFO_BJP_BGTZ = 5;
    typedef enum logic {
        MIPS_BRU_ST_IDLE  = 1'b0,
        MIPS_BRU_ST_REDIR = 1'b1
    } bru_state_e;
endpackage

// File: rtl/mips_ex_bru_cmp.sv
// mips_ex_bru_cmp: combinational branch condition and target evaluation
module mips_ex_bru_cmp import mips_ex_bru_pkg::*; #(
    parameter int DATA_W = MIPS_DATA_WIDTH,
    parameter int ADDR_W = MIPS_ADDR_WIDTH
) (
    input  logic [DATA_W-1:0]             rs,
    input  logic [DATA_W-1:0]             rt,
    input  logic [DATA_W-1:0]             imm,
    input  logic [ADDR_W-1:0]             pc_incr,
    input  logic [MIPS_DECINFO_WIDTH-1:0] info,
    output logic                          is_br,
    output logic                          taken,
    output logic [ADDR_W-1:0]             target
);
    logic neg, zero, unused_bits;
    assign unused_bits = ^{imm[DATA_W-1:ADDR_W-2], info[MIPS_DECINFO_WIDTH-1:MIPS_DECINFO_BJP_BGTZ+1]};
    always_comb begin
        neg    = rs[DATA_W-1];
        zero   = (rs == '0);
        is_br  = |info[MIPS_DECINFO_BJP_BGTZ:MIPS_DECINFO_BJP_BEQ];
        // Multi-hot decode is illegal; the chain below fixes a deterministic priority anyway
        taken  = info[MIPS_DECINFO_BJP_BEQ]  ? (rs == rt) :
                 info[MIPS_DECINFO_BJP_BNE]  ? (rs != rt) :
                 info[MIPS_DECINFO_BJP_BGEZ] ? !neg :
                 info[MIPS_DECINFO_BJP_BLTZ] ? neg :
                 info[MIPS_DECINFO_BJP_BLEZ] ? (neg || zero) :
                 (info[MIPS_DECINFO_BJP_BGTZ] && !neg && !zero);
        target = pc_incr + {imm[ADDR_W-3:0], 2'b00};
    end
endmodule

// File: rtl/mips_ex_bru.sv
// mips_ex_bru: EX branch resolution with predictor update, flush and redirect; MIPS_BRU_STATS_EN adds counters
module mips_ex_bru import mips_ex_bru_pkg::*; #(
    parameter int DATA_W = MIPS_DATA_WIDTH,
    parameter int ADDR_W = MIPS_ADDR_WIDTH,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bru_i_valid,
    output logic                          bru_i_ready,
    input  logic [DATA_W-1:0]             bru_i_rs,
    input  logic [DATA_W-1:0]             bru_i_rt,
    input  logic [DATA_W-1:0]             bru_i_imm,
    input  logic [ADDR_W-1:0]             bru_i_pc_incr,
    input  logic [MIPS_DECINFO_WIDTH-1:0] bru_i_info,
    input  logic                          bru_i_pred_taken,
    output logic                          bru_o_flush,
    output logic                          bru_o_redir_valid,
    input  logic                          bru_o_redir_ready,
    output logic [ADDR_W-1:0]             bru_o_redir_pc,
    output logic                          bru_o_upd_valid,
    output logic [ADDR_W-1:0]             bru_o_upd_pc,
    output logic                          bru_o_upd_taken,
    output logic [CNT_W-1:0]              bru_o_br_cnt,
    output logic [CNT_W-1:0]              bru_o_mis_cnt
);
    bru_state_e        state_q, state_d;
    logic              flush_q, flush_d, redir_valid_q, redir_valid_d;
    logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d, upd_pc_q, upd_pc_d, target;
    logic              is_br, taken, accept, resolve, mispred;

    mips_ex_bru_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp (
        .rs(bru_i_rs), .rt(bru_i_rt), .imm(bru_i_imm), .pc_incr(bru_i_pc_incr),
        .info(bru_i_info), .is_br(is_br), .taken(taken), .target(target)
    );

    // Ready is masked by reset so every output reads 0 while rst_n is low
    assign bru_i_ready = rst_n && (state_q == MIPS_BRU_ST_IDLE);

    always_comb begin
        accept        = bru_i_valid && bru_i_ready;
        resolve       = accept && is_br;
        mispred       = resolve && (taken != bru_i_pred_taken);
        state_d       = (state_q == MIPS_BRU_ST_IDLE) ? (mispred ? MIPS_BRU_ST_REDIR : MIPS_BRU_ST_IDLE)
                                                      : (bru_o_redir_ready ? MIPS_BRU_ST_IDLE : MIPS_BRU_ST_REDIR);
        flush_d       = mispred;
        redir_valid_d = mispred || (redir_valid_q && !bru_o_redir_ready);
        redir_pc_d    = mispred ? (taken ? target : bru_i_pc_incr) : redir_pc_q;
        upd_valid_d   = resolve;
        upd_pc_d      = resolve ? bru_i_pc_incr - ADDR_W'(4) : upd_pc_q;
        upd_taken_d   = resolve ? taken : upd_taken_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MIPS_BRU_ST_IDLE;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
        end
    end

    assign bru_o_flush       = flush_q;
    assign bru_o_redir_valid = redir_valid_q;
    assign bru_o_redir_pc    = redir_pc_q;
    assign bru_o_upd_valid   = upd_valid_q;
    assign bru_o_upd_pc      = upd_pc_q;
    assign bru_o_upd_taken   = upd_taken_q;

`ifdef MIPS_BRU_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    always_comb begin
        br_cnt_d  = (resolve && !(&br_cnt_q)) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        mis_cnt_d = (mispred && !(&mis_cnt_q)) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end
    assign bru_o_br_cnt  = br_cnt_q;
    assign bru_o_mis_cnt = mis_cnt_q;
`else
    assign bru_o_br_cnt  = '0;
    assign bru_o_mis_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_ex_bru.sv
// tb_mips_ex_bru: directed and randomized checks of mips_ex_bru against a behavioural model
module tb_mips_ex_bru;
    import mips_ex_bru_pkg::*;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 2;
    localparam int IW = MIPS_DECINFO_WIDTH;
`ifdef MIPS_BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid, i_ready, i_pred, flush, redir_valid, redir_ready, upd_valid, upd_taken;
    logic [DW-1:0] i_rs, i_rt, i_imm;
    logic [AW-1:0] i_pc, redir_pc, upd_pc;
    logic [IW-1:0] i_info;
    logic [CW-1:0] br_cnt, mis_cnt;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    mips_ex_bru #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bru_i_valid(i_valid), .bru_i_ready(i_ready),
        .bru_i_rs(i_rs), .bru_i_rt(i_rt), .bru_i_imm(i_imm), .bru_i_pc_incr(i_pc),
        .bru_i_info(i_info), .bru_i_pred_taken(i_pred), .bru_o_flush(flush),
        .bru_o_redir_valid(redir_valid), .bru_o_redir_ready(redir_ready),
        .bru_o_redir_pc(redir_pc), .bru_o_upd_valid(upd_valid), .bru_o_upd_pc(upd_pc),
        .bru_o_upd_taken(upd_taken), .bru_o_br_cnt(br_cnt), .bru_o_mis_cnt(mis_cnt)
    );

    // Reference branch semantics using signed integer arithmetic
    function automatic logic ref_taken(input logic [IW-1:0] inf, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s = a;
        if (inf[MIPS_DECINFO_BJP_BEQ])  return a == b;
        if (inf[MIPS_DECINFO_BJP_BNE])  return a != b;
        if (inf[MIPS_DECINFO_BJP_BGEZ]) return s >= 0;
        if (inf[MIPS_DECINFO_BJP_BLTZ]) return s < 0;
        if (inf[MIPS_DECINFO_BJP_BLEZ]) return s <= 0;
        if (inf[MIPS_DECINFO_BJP_BGTZ]) return s > 0;
        return 1'b0;
    endfunction

    logic          e_pend, e_flush, e_upd_valid, e_upd_taken;
    logic [AW-1:0] e_redir_pc, e_upd_pc;
    logic [CW-1:0] e_br, e_mis;
    logic          m_acc, m_res, m_mis, m_taken;
    assign m_taken = ref_taken(i_info, i_rs, i_rt);
    assign m_acc   = i_valid && rst_n && !e_pend;
    assign m_res   = m_acc && (i_info[5:0] != 6'd0);
    assign m_mis   = m_res && (m_taken != i_pred);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_pend <= 1'b0; e_flush <= 1'b0; e_upd_valid <= 1'b0; e_upd_taken <= 1'b0;
            e_redir_pc <= '0; e_upd_pc <= '0; e_br <= '0; e_mis <= '0;
        end else begin
            e_upd_valid <= m_res;
            e_flush     <= m_mis;
            e_pend      <= e_pend ? !redir_ready : m_mis;
            if (m_res) begin
                e_upd_pc    <= i_pc - 32'd4;
                e_upd_taken <= m_taken;
            end
            if (m_mis) e_redir_pc <= m_taken ? i_pc + i_imm * 32'd4 : i_pc;
            if (STATS && m_res && e_br != 2'd3) e_br <= e_br + 2'd1;
            if (STATS && m_mis && e_mis != 2'd3) e_mis <= e_mis + 2'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_ready", 32'(i_ready), 32'(rst_n && !e_pend));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_redir_valid", 32'(redir_valid), 32'(e_pend));
        if (e_pend) chk("m_redir_pc", redir_pc, e_redir_pc);
        chk("m_upd_valid", 32'(upd_valid), 32'(e_upd_valid));
        if (e_upd_valid) begin
            chk("m_upd_pc", upd_pc, e_upd_pc);
            chk("m_upd_taken", 32'(upd_taken), 32'(e_upd_taken));
        end
        chk("m_br_cnt", 32'(br_cnt), 32'(e_br));
        chk("m_mis_cnt", 32'(mis_cnt), 32'(e_mis));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input int op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [31:0] pc, input logic pred);
        i_valid = 1'b1;
        i_info  = (op == 0) ? '0 : IW'(1) << (op - 1);
        i_rs = rs; i_rt = rt; i_imm = imm; i_pc = pc; i_pred = pred;
    endtask

    task automatic mispredict_op();
        drive(1, 32'd3, 32'd3, 32'd4, 32'h500, 1'b0);
        step();
        i_valid = 1'b0;
        step();
    endtask

    initial begin
        i_valid = 0; i_rs = 0; i_rt = 0; i_imm = 0; i_pc = 0; i_info = 0; i_pred = 0; redir_ready = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(i_ready), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_br_cnt", 32'(br_cnt), 32'd0);
        rst_n = 1'b1;
        #1 chk("rel_ready", 32'(i_ready), 32'd1);
        step();
        // Correctly predicted BEQ
        drive(1, 32'd5, 32'd5, 32'd0, 32'h100, 1'b1);
        step();
        i_valid = 1'b0;
        chk("t1_upd_valid", 32'(upd_valid), 32'd1);
        chk("t1_upd_taken", 32'(upd_taken), 32'd1);
        chk("t1_upd_pc", upd_pc, 32'hFC);
        chk("t1_flush", 32'(flush), 32'd0);
        chk("t1_redir_valid", 32'(redir_valid), 32'd0);
        // BNE mispredict held while IF stalls, with a pending op that must not be taken
        drive(2, 32'd7, 32'd7, 32'd3, 32'h104, 1'b1);
        step();
        chk("t2_flush", 32'(flush), 32'd1);
        chk("t2_redir_valid", 32'(redir_valid), 32'd1);
        chk("t2_redir_pc", redir_pc, 32'h104);
        chk("t2_upd_taken", 32'(upd_taken), 32'd0);
        drive(1, 32'd1, 32'd1, 32'd0, 32'h300, 1'b0);
        repeat (3) begin
            step();
            chk("t2_hold_valid", 32'(redir_valid), 32'd1);
            chk("t2_hold_pc", redir_pc, 32'h104);
            chk("t2_hold_ready", 32'(i_ready), 32'd0);
            chk("t2_hold_flush", 32'(flush), 32'd0);
            chk("t2_hold_upd", 32'(upd_valid), 32'd0);
        end
        i_valid = 1'b0;
        redir_ready = 1'b1;
        step();
        chk("t2_idle_ready", 32'(i_ready), 32'd1);
        chk("t2_idle_redir", 32'(redir_valid), 32'd0);
        // BLTZ on most negative value, backward target
        drive(4, 32'h80000000, 32'd0, 32'hFFFFFFFE, 32'h200, 1'b0);
        step();
        i_valid = 1'b0;
        chk("t3_taken", 32'(upd_taken), 32'd1);
        chk("t3_flush", 32'(flush), 32'd1);
        chk("t3_redir_pc", redir_pc, 32'h1F8);
        step();
        chk("t3_idle", 32'(i_ready), 32'd1);
        // BGEZ target wraps past the top of the address space
        drive(3, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFC, 1'b0);
        step();
        i_valid = 1'b0;
        chk("t4_redir_pc", redir_pc, 32'h0);
        chk("t4_upd_pc", upd_pc, 32'hFFFFFFF8);
        step();
        // Asynchronous reset in the middle of a redirect
        redir_ready = 1'b0;
        drive(2, 32'd1, 32'd2, 32'd8, 32'h400, 1'b0);
        step();
        i_valid = 1'b0;
        chk("t5_pre_redir", 32'(redir_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_flush", 32'(flush), 32'd0);
        chk("t5_redir_valid", 32'(redir_valid), 32'd0);
        chk("t5_redir_pc", redir_pc, 32'd0);
        chk("t5_upd_valid", 32'(upd_valid), 32'd0);
        chk("t5_upd_pc", upd_pc, 32'd0);
        chk("t5_ready", 32'(i_ready), 32'd0);
        @(negedge clk);
        check_model();
        rst_n = 1'b1;
        #1 chk("t5_rel_ready", 32'(i_ready), 32'd1);
        step();
        // Statistics: mispredict, correct prediction, non-branch, then saturation
        redir_ready = 1'b1;
        mispredict_op();
        drive(1, 32'd3, 32'd4, 32'd0, 32'h600, 1'b0);
        step();
        drive(0, 32'd3, 32'd3, 32'd0, 32'h700, 1'b0);
        step();
        i_valid = 1'b0;
        chk("t6_nobr_upd", 32'(upd_valid), 32'd0);
        chk("t6_nobr_flush", 32'(flush), 32'd0);
        chk("t6_br_cnt_2", 32'(br_cnt), STATS ? 32'd2 : 32'd0);
        chk("t6_mis_cnt_1", 32'(mis_cnt), STATS ? 32'd1 : 32'd0);
        repeat (4) mispredict_op();
        chk("t6_br_sat", 32'(br_cnt), STATS ? 32'd3 : 32'd0);
        chk("t6_mis_sat", 32'(mis_cnt), STATS ? 32'd3 : 32'd0);
        // Randomized traffic
        repeat (3000) begin
            int k = $urandom_range(0, 6);
            int r = $urandom_range(0, 4);
            i_valid     = ($urandom % 4) != 0;
            i_info      = IW'($urandom);
            i_info[5:0] = (k == 0) ? 6'd0 : 6'(1 << (k - 1));
            i_rs        = (r == 0) ? 32'd0 : (r == 1) ? 32'h80000000 : (r == 2) ? 32'd1 : $urandom;
            i_rt        = ($urandom % 3 == 0) ? i_rs : $urandom;
            i_imm       = ($urandom % 2 == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : $urandom;
            i_pc        = {$urandom, 2'b00} & 32'hFFFFFFFC;
            i_pred      = $urandom % 2;
            redir_ready = ($urandom % 3) == 0;
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
